// File: rtl/spi_target.sv
// SPI mode-0 target byte transceiver: oversampled pins, rx byte/valid stream, tx byte request and shift-out.
// Optional `define SPI_GLITCH_FILTER_EN adds a 3-sample majority filter on sck/cs_n (+2 clk latency).
module spi_target #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_MISO   = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       start,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic [7:0] wr_data,
    output logic       wr_valid
);

    // Cycles after reset before the cs_n path holds only pin-derived samples.
    localparam int                 FLUSH_CYC = SYNC_STAGES + 4;
    localparam int                 FLUSH_W   = $clog2(FLUSH_CYC + 1);
    localparam logic [FLUSH_W-1:0] FLUSH_MAX = FLUSH_W'(FLUSH_CYC);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_cur;
    logic                   cs_cur;
    logic                   mosi_cur;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        end
    end

`ifdef SPI_GLITCH_FILTER_EN
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [1:0] sck_hist;
    logic [1:0] cs_hist;
    logic [1:0] mosi_dly;
    logic       sck_flt;
    logic       cs_flt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sck_hist <= 2'b00;
            cs_hist  <= 2'b11;
            mosi_dly <= 2'b00;
            sck_flt  <= 1'b0;
            cs_flt   <= 1'b1;
        end else begin
            sck_hist <= {sck_hist[0], sck_sync[SYNC_STAGES-1]};
            cs_hist  <= {cs_hist[0], cs_sync[SYNC_STAGES-1]};
            mosi_dly <= {mosi_dly[0], mosi_sync[SYNC_STAGES-1]};
            sck_flt  <= maj3(sck_sync[SYNC_STAGES-1], sck_hist[0], sck_hist[1]);
            cs_flt   <= maj3(cs_sync[SYNC_STAGES-1], cs_hist[0], cs_hist[1]);
        end
    end

    assign sck_cur  = sck_flt;
    assign cs_cur   = cs_flt;
    assign mosi_cur = mosi_dly[1];
`else
    assign sck_cur  = sck_sync[SYNC_STAGES-1];
    assign cs_cur   = cs_sync[SYNC_STAGES-1];
    assign mosi_cur = mosi_sync[SYNC_STAGES-1];
`endif

    logic               sck_q;
    logic               cs_q;
    logic [FLUSH_W-1:0] flush_cnt;
    logic               armed;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sck_q     <= 1'b0;
            cs_q      <= 1'b1;
            flush_cnt <= '0;
            armed     <= 1'b0;
        end else begin
            sck_q <= sck_cur;
            cs_q  <= cs_cur;
            if (flush_cnt != FLUSH_MAX)
                flush_cnt <= flush_cnt + 1'b1;
            // Reset values in the sync chain must not count as "cs_n seen high".
            if (flush_cnt == FLUSH_MAX && cs_cur)
                armed <= 1'b1;
        end
    end

    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] rx_next;
    logic [7:0] tx_shift;
    logic       sck_rise;
    logic       sck_fall;
    logic       cs_fall;
    logic       selected;
    logic       start_evt;
    logic       bit_evt;
    logic       byte_done;
    logic       shift_evt;

    always_comb begin
        sck_rise  = sck_cur & ~sck_q;
        sck_fall  = ~sck_cur & sck_q;
        cs_fall   = ~cs_cur & cs_q;
        selected  = armed & ~cs_cur;
        start_evt = selected & cs_fall;
        bit_evt   = selected & sck_rise & ~start_evt;
        byte_done = bit_evt & (bit_cnt == 3'd7);
        // Byte-boundary falling edge keeps the freshly loaded MSB on the wire.
        shift_evt = selected & sck_fall & (bit_cnt != 3'd0) & ~start_evt;
        rx_next   = {rx_shift, mosi_cur};
    end

    // Stage p0: rd_valid, p1: wr_valid, p1..p3: pending tx load.
    logic vld_p0;
    logic vld_p1;
    logic ld_p1;
    logic ld_p2;
    logic ld_p3;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_cnt <= 3'd0;
            start   <= 1'b0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            ld_p1   <= 1'b0;
            ld_p2   <= 1'b0;
            ld_p3   <= 1'b0;
        end else begin
            start <= start_evt;
            if (start_evt || !selected)
                bit_cnt <= 3'd0;
            else if (bit_evt)
                bit_cnt <= bit_cnt + 3'd1;
            vld_p0 <= byte_done;
            vld_p1 <= vld_p0;
            // A new start cancels an outstanding load; a plain deselect does not.
            ld_p1  <= vld_p0 & ~start_evt;
            ld_p2  <= ld_p1 & ~start_evt;
            ld_p3  <= ld_p2 & ~start_evt;
        end
    end

    always_ff @(posedge clk) begin
        if (bit_evt)
            rx_shift <= rx_next[6:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data  <= 8'h00;
            tx_shift <= {8{IDLE_MISO}};
        end else begin
            if (byte_done)
                rd_data <= rx_next;
            if (start_evt)
                tx_shift <= {8{IDLE_MISO}};
            else if (ld_p3)
                tx_shift <= wr_data;
            else if (shift_evt)
                tx_shift <= {tx_shift[6:0], 1'b0};
        end
    end

    assign spi_miso    = tx_shift[7];
    assign spi_miso_oe = ~cs_cur;
    assign rd_valid    = vld_p0;
    assign wr_valid    = vld_p1;

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: bit-banged SPI controller, registered consumer, queue-based reference model.
module tb_spi_target;

`ifdef SPI_GLITCH_FILTER_EN
    localparam int HALF = 6;
`else
    localparam int HALF = 4;
`endif

    logic       clk = 1'b0;
    logic       reset_n, spi_sck, spi_cs_n, spi_mosi;
    logic       spi_miso, spi_miso_oe, start, rd_valid, wr_valid;
    logic [7:0] rd_data, wr_data;

    always #5 clk = ~clk;

    spi_target dut (
        .clk(clk), .reset_n(reset_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .start(start), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_data(wr_data), .wr_valid(wr_valid)
    );

    int n_chk = 0, n_fail = 0;
    int cyc = 0, n_start = 0, n_rd = 0, n_wr = 0, last_rd_cyc = -10, bad_wr = 0, bad_ovl = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_hist[$];
    logic       fixed_en = 1'b0;
    logic [7:0] fixed_val = 8'h00;
    logic [7:0] txb[0:7];
    logic [7:0] miso_got[0:7];
    logic       early_got[0:7];

    // Event monitor: counts pulses, collects received bytes, tracks rd->wr spacing.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (start === 1'b1) n_start++;
            if (rd_valid === 1'b1) begin
                n_rd++;
                rx_q.push_back(rd_data);
                last_rd_cyc = cyc;
            end
            if (wr_valid === 1'b1) begin
                n_wr++;
                if (cyc != last_rd_cyc + 1) bad_wr++;
            end
            if (rd_valid === 1'b1 && wr_valid === 1'b1) bad_ovl++;
        end
    end

    // Registered consumer: presents the next tx byte one cycle after wr_valid.
    initial begin : consumer
        logic [7:0] v;
        forever begin
            @(negedge clk);
            if (wr_valid === 1'b1) begin
                @(posedge clk);
                #1;
                v = fixed_en ? fixed_val : 8'($urandom);
                wr_data = v;
                tx_hist.push_back(v);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic spi_byte(input logic [7:0] b, input int nbits, input logic [7:0] gmask,
                            output logic [7:0] m, output logic e);
        m = 8'h00;
        e = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7-i];
            if (gmask[7-i]) begin
                wait_clk(2);
                spi_sck = 1'b1;
                wait_clk(1);
                spi_sck = 1'b0;
                wait_clk(HALF - 4);
            end else begin
                wait_clk(HALF - 1);
            end
            if (i == 0) e = spi_miso;
            wait_clk(1);
            m[7-i] = spi_miso;
            spi_sck = 1'b1;
            wait_clk(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic do_txn(input int n);
        logic [7:0] m;
        logic       e;
        tx_hist.delete();
        spi_cs_n = 1'b0;
        wait_clk(HALF + 2);
        for (int i = 0; i < n; i++) begin
            spi_byte(txb[i], 8, 8'h00, m, e);
            miso_got[i]  = m;
            early_got[i] = e;
        end
        wait_clk(HALF);
        spi_cs_n = 1'b1;
        wait_clk(HALF + 4);
    endtask

    task automatic test_reset();
        int s0;
        reset_n = 1'b0; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0; wr_data = 8'h00;
        wait_clk(4);
        n_chk++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b want 0", start); end
        n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        n_chk++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid got %b want 0", wr_valid); end
        n_chk++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
        n_chk++; if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got %b want 0", spi_miso_oe); end
        n_chk++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso got %b want 0", spi_miso); end
        reset_n = 1'b1;
        wait_clk(10);
        n_chk++; if (n_start !== 0) begin n_fail++; $display("FAIL idle_no_start got %0d want 0", n_start); end
        s0 = n_start;
        spi_cs_n = 1'b0;
        wait_clk(10);
        n_chk++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL first_start count got %0d want 1", n_start - s0); end
        n_chk++; if (spi_miso_oe !== 1'b1) begin n_fail++; $display("FAIL selected_oe got %b want 1", spi_miso_oe); end
        n_chk++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL selected_miso got %b want 0", spi_miso); end
        spi_cs_n = 1'b1;
        wait_clk(10);
    endtask

    task automatic test_stream();
        int b, r0, w0, s0;
        logic [7:0] got, exp;
        txb[0] = 8'h03; txb[1] = 8'h00; txb[2] = 8'h00; txb[3] = 8'h01;
        b = rx_q.size(); r0 = n_rd; w0 = n_wr; s0 = n_start;
        do_txn(4);
        for (int i = 0; i < 4; i++) begin
            got = (rx_q.size() > b + i) ? rx_q[b+i] : 8'hxx;
            n_chk++; if (got !== txb[i]) begin n_fail++; $display("FAIL stream_rx[%0d] got %h want %h", i, got, txb[i]); end
            exp = (i == 0) ? 8'h00 : ((tx_hist.size() >= i) ? tx_hist[i-1] : 8'hxx);
            n_chk++; if (miso_got[i] !== exp) begin n_fail++; $display("FAIL stream_miso[%0d] got %h want %h", i, miso_got[i], exp); end
        end
        n_chk++; if (n_rd - r0 !== 4) begin n_fail++; $display("FAIL stream_rd_count got %0d want 4", n_rd - r0); end
        n_chk++; if (n_wr - w0 !== 4) begin n_fail++; $display("FAIL stream_wr_count got %0d want 4", n_wr - w0); end
        n_chk++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL stream_start got %0d want 1", n_start - s0); end
    endtask

    task automatic test_miso_load();
        int b;
        logic [7:0] got;
        fixed_en = 1'b1; fixed_val = 8'hA5;
        txb[0] = 8'($urandom); txb[1] = 8'($urandom);
        b = rx_q.size();
        do_txn(2);
        fixed_en = 1'b0;
        n_chk++; if (miso_got[0] !== 8'h00) begin n_fail++; $display("FAIL load_first_idle got %h want 00", miso_got[0]); end
        n_chk++; if (early_got[0] !== 1'b0) begin n_fail++; $display("FAIL load_first_early got %b want 0", early_got[0]); end
        n_chk++; if (miso_got[1] !== 8'hA5) begin n_fail++; $display("FAIL load_miso got %h want a5", miso_got[1]); end
        n_chk++; if (early_got[1] !== 1'b1) begin n_fail++; $display("FAIL load_msb_early got %b want 1", early_got[1]); end
        for (int i = 0; i < 2; i++) begin
            got = (rx_q.size() > b + i) ? rx_q[b+i] : 8'hxx;
            n_chk++; if (got !== txb[i]) begin n_fail++; $display("FAIL load_rx[%0d] got %h want %h", i, got, txb[i]); end
        end
    endtask

    task automatic test_abort();
        int b, r0, w0, s0;
        logic [7:0] m, got;
        logic e;
        b = rx_q.size(); r0 = n_rd; w0 = n_wr; s0 = n_start;
        spi_cs_n = 1'b0;
        wait_clk(HALF + 2);
        spi_byte(8'hFF, 5, 8'h00, m, e);
        wait_clk(HALF);
        spi_cs_n = 1'b1;
        wait_clk(HALF + 4);
        n_chk++; if (n_rd - r0 !== 0) begin n_fail++; $display("FAIL abort_no_rd got %0d want 0", n_rd - r0); end
        n_chk++; if (n_wr - w0 !== 0) begin n_fail++; $display("FAIL abort_no_wr got %0d want 0", n_wr - w0); end
        txb[0] = 8'h5A;
        do_txn(1);
        got = (rx_q.size() > b) ? rx_q[b] : 8'hxx;
        n_chk++; if (got !== 8'h5A) begin n_fail++; $display("FAIL abort_rx got %h want 5a", got); end
        n_chk++; if (n_rd - r0 !== 1) begin n_fail++; $display("FAIL abort_rd_count got %0d want 1", n_rd - r0); end
        n_chk++; if (n_start - s0 !== 2) begin n_fail++; $display("FAIL abort_starts got %0d want 2", n_start - s0); end
        n_chk++; if (miso_got[0] !== 8'h00) begin n_fail++; $display("FAIL abort_miso got %h want 00", miso_got[0]); end
    endtask

    task automatic test_armed();
        int b, r0, w0, s0;
        logic [7:0] m, got;
        logic e;
        spi_cs_n = 1'b0;
        wait_clk(4);
        reset_n = 1'b0;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(10);
        r0 = n_rd; w0 = n_wr; s0 = n_start;
        spi_byte(8'h77, 8, 8'h00, m, e);
        wait_clk(HALF + 4);
        n_chk++; if (n_start - s0 !== 0) begin n_fail++; $display("FAIL unarmed_start got %0d want 0", n_start - s0); end
        n_chk++; if (n_rd - r0 !== 0) begin n_fail++; $display("FAIL unarmed_rd got %0d want 0", n_rd - r0); end
        n_chk++; if (n_wr - w0 !== 0) begin n_fail++; $display("FAIL unarmed_wr got %0d want 0", n_wr - w0); end
        spi_cs_n = 1'b1;
        wait_clk(10);
        b = rx_q.size(); s0 = n_start;
        txb[0] = 8'h77;
        do_txn(1);
        got = (rx_q.size() > b) ? rx_q[b] : 8'hxx;
        n_chk++; if (got !== 8'h77) begin n_fail++; $display("FAIL armed_rx got %h want 77", got); end
        n_chk++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL armed_start got %0d want 1", n_start - s0); end
    endtask

    task automatic test_back_to_back();
        int b, r0, n;
        logic [7:0] got, exp;
        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) txb[i] = 8'($urandom);
            b = rx_q.size(); r0 = n_rd;
            do_txn(n);
            for (int i = 0; i < n; i++) begin
                got = (rx_q.size() > b + i) ? rx_q[b+i] : 8'hxx;
                n_chk++; if (got !== txb[i]) begin n_fail++; $display("FAIL b2b_rx[%0d.%0d] got %h want %h", t, i, got, txb[i]); end
                exp = (i == 0) ? 8'h00 : ((tx_hist.size() >= i) ? tx_hist[i-1] : 8'hxx);
                n_chk++; if (miso_got[i] !== exp) begin n_fail++; $display("FAIL b2b_miso[%0d.%0d] got %h want %h", t, i, miso_got[i], exp); end
            end
            n_chk++; if (n_rd - r0 !== n) begin n_fail++; $display("FAIL b2b_rd_count[%0d] got %0d want %0d", t, n_rd - r0, n); end
        end
    endtask

`ifdef SPI_GLITCH_FILTER_EN
    task automatic test_glitch();
        int b, r0;
        logic [7:0] m, got;
        logic e;
        b = rx_q.size(); r0 = n_rd;
        spi_cs_n = 1'b0;
        wait_clk(HALF + 2);
        spi_byte(8'hC3, 8, 8'h24, m, e);
        spi_byte(8'h3C, 8, 8'h00, m, e);
        wait_clk(HALF);
        spi_cs_n = 1'b1;
        wait_clk(HALF + 4);
        got = (rx_q.size() > b) ? rx_q[b] : 8'hxx;
        n_chk++; if (got !== 8'hC3) begin n_fail++; $display("FAIL glitch_rx got %h want c3", got); end
        got = (rx_q.size() > b + 1) ? rx_q[b+1] : 8'hxx;
        n_chk++; if (got !== 8'h3C) begin n_fail++; $display("FAIL glitch_next_rx got %h want 3c", got); end
        n_chk++; if (n_rd - r0 !== 2) begin n_fail++; $display("FAIL glitch_rd_count got %0d want 2", n_rd - r0); end
    endtask
`endif

    task automatic test_invariants();
        n_chk++; if (bad_wr !== 0) begin n_fail++; $display("FAIL wr_after_rd misplaced got %0d want 0", bad_wr); end
        n_chk++; if (bad_ovl !== 0) begin n_fail++; $display("FAIL rd_wr_overlap got %0d want 0", bad_ovl); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_miso_load();
        test_abort();
        test_armed();
        test_back_to_back();
`ifdef SPI_GLITCH_FILTER_EN
        test_glitch();
`endif
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
